// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller: each DATA_W word becomes N = DATA_W/SRAM_DW narrow SRAM accesses of
// WAIT_CYC cycles each, with the pipeline frozen meanwhile. Define SRAM_RD_BUF_EN for a one-word read buffer.
module sram_mem_ctrl #(
    parameter int DATA_W    = 32,
    parameter int SRAM_DW   = 16,
    parameter int SRAM_AW   = 18,
    parameter int WAIT_CYC  = 5,
    parameter int BASE_ADDR = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read_en,
    input  logic               mem_write_en,
    input  logic [31:0]        addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_wdata,
    input  logic [SRAM_DW-1:0] sram_rdata,
    output logic               sram_we_n,
    output logic               sram_dq_oe
);

    localparam int N       = DATA_W / SRAM_DW;
    localparam int HW      = (N > 1) ? $clog2(N) : 1;
    localparam int CW      = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam int BYTE_SH = $clog2(DATA_W / 8);

    localparam logic [HW-1:0]      H_LAST      = HW'(N - 1);
    localparam logic [CW-1:0]      C_LAST      = CW'(WAIT_CYC - 1);
    localparam logic [HW-1:0]      ONE_H       = HW'(1);
    localparam logic [CW-1:0]      ONE_C       = CW'(1);
    localparam logic [SRAM_AW-1:0] ONE_A       = SRAM_AW'(1);
    // With a single wait cycle the strobe cannot skip the first cycle of a half.
    localparam logic               WE_AT_START = (WAIT_CYC == 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state;
    logic [HW-1:0]      h;
    logic [CW-1:0]      cnt;
    logic               op_write;
    logic [DATA_W-1:0]  wshift;
    logic [DATA_W-1:0]  rd_shadow;
    logic [DATA_W-1:0]  rd_merged;
    logic [31:0]        req_w;
    logic [SRAM_AW-1:0] req_base;
    logic               request;
    logic               buf_hit;
    logic [DATA_W-1:0]  buf_data;
    logic               accept;
    logic               half_end;
    logic               last_half;
    logic               read_done;

    assign request   = mem_read_en | mem_write_en;
    assign req_w     = (addr - 32'(BASE_ADDR)) >> BYTE_SH;
    assign req_base  = SRAM_AW'(req_w * 32'(N));
    assign accept    = (state == IDLE) && request && !buf_hit;
    assign half_end  = (state == ACCESS) && (cnt == C_LAST);
    assign last_half = (h == H_LAST);
    assign read_done = half_end && last_half && !op_write;
    assign freeze    = ((state == IDLE) && request) || (state == ACCESS);

    // Halves arrive low first, so each capture shifts in from the top.
    assign rd_merged = DATA_W'({sram_rdata, rd_shadow} >> SRAM_DW);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            h          <= '0;
            cnt        <= '0;
            op_write   <= 1'b0;
            rdata      <= '0;
            ready      <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
        end else begin
            ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (buf_hit) begin
                        state <= DONE;
                        ready <= 1'b1;
                        rdata <= buf_data;
                    end else if (request) begin
                        state      <= ACCESS;
                        h          <= '0;
                        cnt        <= '0;
                        op_write   <= mem_write_en;
                        sram_addr  <= req_base;
                        sram_wdata <= wdata[SRAM_DW-1:0];
                        sram_dq_oe <= mem_write_en;
                        sram_we_n  <= !(mem_write_en && WE_AT_START);
                    end
                end
                ACCESS: begin
                    if (cnt == C_LAST) begin
                        cnt <= '0;
                        if (last_half) begin
                            state      <= DONE;
                            ready      <= 1'b1;
                            sram_we_n  <= 1'b1;
                            sram_dq_oe <= 1'b0;
                            if (!op_write) rdata <= rd_merged;
                        end else begin
                            h          <= h + ONE_H;
                            sram_addr  <= sram_addr + ONE_A;
                            sram_wdata <= SRAM_DW'(wshift >> SRAM_DW);
                            sram_we_n  <= !(op_write && WE_AT_START);
                        end
                    end else begin
                        cnt       <= cnt + ONE_C;
                        sram_we_n <= !op_write;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: pure datapath registers carry no reset; they are always loaded before being observed.
    always_ff @(posedge clk) begin
        if (accept) wshift <= wdata;
        else if (half_end && !last_half) wshift <= wshift >> SRAM_DW;
        if (half_end && !op_write) rd_shadow <= rd_merged;
    end

`ifdef SRAM_RD_BUF_EN
    logic        buf_valid;
    logic [31:0] buf_w;
    logic [31:0] word_idx;

    assign buf_hit = (state == IDLE) && mem_read_en && !mem_write_en && buf_valid && (buf_w == req_w);

    always_ff @(posedge clk) begin
        if (rst) buf_valid <= 1'b0;
        else if (accept && mem_write_en) buf_valid <= 1'b0;
        else if (read_done) buf_valid <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept) word_idx <= req_w;
        if (read_done) begin
            buf_w    <= word_idx;
            buf_data <= rd_merged;
        end
    end
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

endmodule
